// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage; runs LW/SW/LB/SB over a req/ready handshake
// and holds the MEM/WB register feeding write-back.
module mem_access_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        is_LB_SB,
    input  logic        mem_to_reg,
    input  logic [1:0]  jump,
    input  logic [31:0] pc,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [31:0] inst,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        wb_valid,
    output logic [7:0]  cache_data_out [0:3],
    output logic [1:0]  mem_block,
    output logic        wb_is_LB_SB,
    output logic        wb_mem_to_reg,
    output logic [1:0]  wb_jump,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_inst,
    output logic        misalign_err,
    output logic        timeout_err
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t        state;
    logic [CW-1:0] count;
    logic          mem_op, misalign, last, done, load_wb;
    always_comb begin
        mem_op   = in_valid & (mem_read | mem_write);
        misalign = (state == IDLE) & mem_op & ~is_LB_SB & (alu_result[1:0] != 2'b00);
        last     = count == CW'(MAX_WAIT - 1);
        done     = (state == WAIT) & (mem_ready | last);
        stall    = (state == IDLE) ? mem_op & ~misalign : ~done;
        load_wb  = ((state == IDLE) & ~stall) | done;
    end
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state        <= IDLE;
            count        <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else if (state == IDLE) begin
            misalign_err <= misalign_err | misalign;
            if (stall) begin
                state     <= WAIT;
                count     <= '0;
                mem_req   <= 1'b1;
                mem_we    <= mem_write;
                mem_addr  <= {alu_result[31:2], 2'b00};
                mem_be    <= (mem_write & is_LB_SB) ? 4'b1000 >> alu_result[1:0] : 4'b1111;
                mem_wdata <= is_LB_SB ? {4{store_data[7:0]}} : store_data;
            end
        end else if (done) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            timeout_err <= timeout_err | ~mem_ready;
        end else begin
            count <= count + CW'(1);
        end
    end
    // MEM/WB register: loads whenever the instruction leaves this stage
    always_ff @(posedge clk) begin
        if (rst_b) begin
            wb_valid       <= 1'b0;
            cache_data_out <= '{default: 8'h00};
            mem_block      <= '0;
            wb_is_LB_SB    <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            wb_jump        <= '0;
            wb_pc          <= '0;
            wb_alu_result  <= '0;
            wb_inst        <= '0;
        end else begin
            wb_valid <= (state == IDLE) ? in_valid & ~stall : done;
            if (load_wb) begin
                if (done & mem_ready & ~mem_write)
                    cache_data_out <= '{mem_rdata[31:24], mem_rdata[23:16], mem_rdata[15:8], mem_rdata[7:0]};
                else
                    cache_data_out <= '{default: 8'h00};
                mem_block     <= alu_result[1:0];
                wb_is_LB_SB   <= is_LB_SB;
                wb_mem_to_reg <= mem_to_reg & ~misalign;
                wb_jump       <= jump;
                wb_pc         <= pc;
                wb_alu_result <= alu_result;
                wb_inst       <= inst;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized bench with a per-instruction reference model
// acting as both upstream pipeline and memory responder.
module tb_mem_access_stage;
    localparam int MAXW = 4;
    logic        clk = 1'b0, rst_b = 1'b1;
    logic        in_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, is_LB_SB = 1'b0, mem_to_reg = 1'b0;
    logic [1:0]  jump = '0;
    logic [31:0] pc = '0, alu_result = '0, store_data = '0, inst = '0, mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall, mem_req, mem_we, wb_valid, wb_is_LB_SB, wb_mem_to_reg, misalign_err, timeout_err;
    logic [31:0] mem_addr, mem_wdata, wb_pc, wb_alu_result, wb_inst;
    logic [3:0]  mem_be;
    logic [1:0]  mem_block, wb_jump;
    logic [7:0]  cache_data_out [0:3];
    int          checks = 0, errors = 0;
    logic        e_stall, e_req, e_we, e_wbv, e_lb, e_m2r, e_mis, e_to;
    logic [31:0] e_addr, e_wdata, e_pc, e_alu, e_inst;
    logic [3:0]  e_be;
    logic [1:0]  e_jump, e_block;
    logic [7:0]  e_cache [0:3];
    logic        chk_en = 1'b0;
    int          stall_cnt = 0, req_cnt = 0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_be = '0;

    mem_access_stage #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
        .is_LB_SB(is_LB_SB), .mem_to_reg(mem_to_reg), .jump(jump), .pc(pc), .alu_result(alu_result),
        .store_data(store_data), .inst(inst), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .wb_valid(wb_valid), .cache_data_out(cache_data_out),
        .mem_block(mem_block), .wb_is_LB_SB(wb_is_LB_SB), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_jump(wb_jump), .wb_pc(wb_pc), .wb_alu_result(wb_alu_result), .wb_inst(wb_inst),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Compare DUT against the model on every checked cycle, away from the clock edge
    always @(negedge clk) begin
        if (chk_en) begin
            if (stall) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata;
            end
            chk("stall", stall, e_stall);
            chk("mem_req", mem_req, e_req);
            if (e_req) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", mem_we, e_we);
                chk("mem_be", mem_be, e_be);
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
            chk("wb_valid", wb_valid, e_wbv);
            if (e_wbv) begin
                chk("wb_is_LB_SB", wb_is_LB_SB, e_lb);
                chk("wb_mem_to_reg", wb_mem_to_reg, e_m2r);
                chk("wb_jump", wb_jump, e_jump);
                chk("wb_pc", wb_pc, e_pc);
                chk("wb_alu_result", wb_alu_result, e_alu);
                chk("wb_inst", wb_inst, e_inst);
                chk("mem_block", mem_block, e_block);
                for (int i = 0; i < 4; i++) chk("cache_data_out", cache_data_out[i], e_cache[i]);
            end
            chk("misalign_err", misalign_err, e_mis);
            chk("timeout_err", timeout_err, e_to);
        end
    end

    // One instruction through MEM; delay = WAIT cycles with ready low before ready rises
    task automatic do_instr(input logic v, input logic rd, input logic wr, input logic lb, input logic m2r,
                            input logic [1:0] j, input logic [31:0] p, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] ins, input int delay,
                            input logic [31:0] rdata);
        logic mem, mis, tmo;
        int   n;
        in_valid = v; mem_read = rd; mem_write = wr; is_LB_SB = lb; mem_to_reg = m2r;
        jump = j; pc = p; alu_result = a; store_data = sd; inst = ins;
        mem_ready = 1'b0; mem_rdata = $urandom;
        mem = v & (rd | wr);
        mis = mem & !lb & (a[1:0] != 2'b00);
        tmo = delay >= MAXW;
        e_stall = mem & !mis;
        if (mem && !mis) begin
            step();
            e_req = 1'b1; e_we = wr; e_addr = {a[31:2], 2'b00};
            e_be = (wr && lb) ? 4'b1000 >> a[1:0] : 4'b1111;
            e_wdata = lb ? {4{sd[7:0]}} : sd;
            e_wbv = 1'b0;
            n = tmo ? MAXW : delay + 1;
            for (int k = 1; k <= n; k++) begin
                e_stall = k < n;
                mem_ready = !tmo && k == n;
                mem_rdata = mem_ready ? rdata : $urandom;
                step();
            end
            mem_ready = 1'b0; e_req = 1'b0; e_to = e_to | tmo;
        end else begin
            step();
        end
        e_wbv = v; e_lb = lb; e_m2r = m2r & !mis; e_jump = j; e_pc = p; e_alu = a; e_inst = ins;
        e_block = a[1:0]; e_mis = e_mis | mis;
        for (int i = 0; i < 4; i++) e_cache[i] = (mem && !mis && !tmo && !wr) ? rdata[31-8*i -: 8] : 8'h00;
    endtask

    initial begin
        logic [31:0] r, a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_errs", {misalign_err, timeout_err}, 0);
        chk("rst_wb_pc", wb_pc, 0);
        rst_b = 1'b0;
        {e_stall, e_req, e_we, e_wbv, e_lb, e_m2r, e_mis, e_to} = '0;
        {e_addr, e_wdata, e_pc, e_alu, e_inst, e_be, e_jump, e_block} = '0;
        for (int i = 0; i < 4; i++) e_cache[i] = 8'h00;
        chk_en = 1'b1;
        stall_cnt = 0;
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h400, 32'h1234, 32'h0, 32'h00851021, 0, 32'h0);
        chk("addu_wbv", wb_valid, 1);
        chk("addu_alu", wb_alu_result, 32'h1234);
        chk("addu_stall", stall_cnt, 0);
        stall_cnt = 0;
        do_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h404, 32'h100, 32'h0, 32'h8c020100, 3, 32'hDEADBEEF);
        chk("lw_stall_cycles", stall_cnt, 4);
        chk("lw_b0", cache_data_out[0], 32'hDE);
        chk("lw_b1", cache_data_out[1], 32'hAD);
        chk("lw_b2", cache_data_out[2], 32'hBE);
        chk("lw_b3", cache_data_out[3], 32'hEF);
        chk("lw_block", mem_block, 0);
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h408, 32'h103, 32'h000000A5, 32'ha0020103, 1, 32'h0);
        chk("sb_be", cap_be, 4'b0001);
        chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        chk("sb_addr", cap_addr, 32'h100);
        do_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h40C, 32'h102, 32'h0, 32'h80020102, 0, 32'h11228033);
        chk("lb_block", mem_block, 2);
        chk("lb_byte", cache_data_out[2], 32'h80);
        chk("lb_flag", wb_is_LB_SB, 1);
        stall_cnt = 0; req_cnt = 0;
        do_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h410, 32'h101, 32'h0, 32'h8c020101, 0, 32'h0);
        chk("mis_err", misalign_err, 1);
        chk("mis_m2r", wb_mem_to_reg, 0);
        chk("mis_stall", stall_cnt, 0);
        chk("mis_noreq", req_cnt, 0);
        req_cnt = 0;
        do_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h414, 32'h200, 32'h0, 32'h8c020200, 50, 32'h0);
        chk("to_req_cycles", req_cnt, 4);
        chk("to_err", timeout_err, 1);
        chk("to_req_low", mem_req, 0);
        for (int t = 0; t < 300; t++) begin
            r = $urandom;
            a = $urandom;
            if (r[7:6] != 2'b00 && !r[3]) a[1:0] = 2'b00;
            do_instr(r[2:0] != 3'b000, r[4], r[5], r[3], r[8], r[10:9], $urandom, a, $urandom, $urandom,
                     int'($urandom_range(0, 5)), $urandom);
        end
        chk_en = 1'b0;
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; is_LB_SB = 1'b0; alu_result = 32'h300;
        step();
        step();
        step();
        chk("pre_rst_req", mem_req, 1);
        rst_b = 1'b1; in_valid = 1'b0; mem_read = 1'b0;
        step();
        chk("midrst_req", mem_req, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_wbv", wb_valid, 0);
        chk("midrst_errs", {misalign_err, timeout_err}, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_be", mem_be, 0);
        chk("midrst_wb_pc", wb_pc, 0);
        chk("midrst_cache", cache_data_out[0], 0);
        chk("midrst_block", mem_block, 0);
        rst_b = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
